// File: rtl/mouse_ps2_tx.sv
// Host-to-device PS/2 transmitter: a CPU write launches one command frame to the mouse and status is read back.
// Optional build macro PS2_TX_TIMEOUT_EN adds an abort when the device stops clocking.
module mouse_ps2_tx #(
    parameter logic [13:0] TX_ADDR        = 14'h2258,
    parameter logic [13:0] STAT_ADDR      = 14'h2260,
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] address,
    input  logic [63:0] write_data,
    input  logic        write,
    input  logic        read,
    output logic [63:0] data,
    input  logic        mouse_clk,
    input  logic        mouse_signal,
    output logic        mouse_clk_oe,
    output logic        mouse_data_oe
);

    // state       | meaning
    // S_IDLE      | no frame in flight, lines released
    // S_INHIBIT   | PS/2 clock held low by the host
    // S_START     | clock still held, data pulled low (start bit)
    // S_SEND      | device clocks out data, parity and stop bits
    // S_ACK       | sample device acknowledge on the next falling edge
    // S_WAIT_IDLE | wait for both lines to return high
    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE
    } state_t;

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

    state_t             state, state_d;
    logic               clk_meta, clk_s, clk_prev, dat_meta, dat_s, fall;
    logic               tx_wr, launch, ack_take, tmo_abort;
    logic [8:0]         shift_q;
    logic [3:0]         bit_cnt;
    logic               send_oe;
    logic [INH_W-1:0]   inh_cnt;
    logic               ack_ok, error, overrun, busy;
    logic               unused_bits;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_meta <= 1'b1;
            clk_s    <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_s    <= 1'b1;
        end else begin
            clk_meta <= mouse_clk;
            clk_s    <= clk_meta;
            clk_prev <= clk_s;
            dat_meta <= mouse_signal;
            dat_s    <= dat_meta;
        end
    end

    assign fall   = clk_prev & ~clk_s;
    assign tx_wr  = write && (address == 64'(TX_ADDR));
    assign launch = tx_wr && (state == S_IDLE);
    assign busy   = (state != S_IDLE);

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Reloaded on every device clock edge, so it only expires when the device goes silent.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state == S_START || fall) begin
            tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
        end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
        end
    end

    assign unused_bits = ^write_data[63:8];
`else
    assign unused_bits = ^{write_data[63:8], 32'(TIMEOUT_CYCLES)};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d       = state;
        mouse_clk_oe  = 1'b0;
        mouse_data_oe = 1'b0;
        ack_take      = 1'b0;
        tmo_abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (launch) state_d = S_INHIBIT;
            end
            S_INHIBIT: begin
                mouse_clk_oe = 1'b1;
                if (inh_cnt == '0) state_d = S_START;
            end
            S_START: begin
                mouse_clk_oe  = 1'b1;
                mouse_data_oe = 1'b1;
                state_d       = S_SEND;
            end
            S_SEND: begin
                mouse_data_oe = send_oe;
                if (fall && bit_cnt == 4'd9) state_d = S_ACK;
            end
            S_ACK: begin
                if (fall) begin
                    ack_take = 1'b1;
                    state_d  = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s && dat_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        if ((state == S_SEND || state == S_ACK || state == S_WAIT_IDLE) && tmo_cnt == '0) begin
            tmo_abort = 1'b1;
            ack_take  = 1'b0;
            state_d   = S_IDLE;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            bit_cnt <= '0;
            send_oe <= 1'b0;
            inh_cnt <= '0;
            ack_ok  <= 1'b0;
            error   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (launch) begin
                shift_q <= {~^write_data[7:0], write_data[7:0]};
                inh_cnt <= INH_W'(INHIBIT_CYCLES - 1);
                ack_ok  <= 1'b0;
                error   <= 1'b0;
                overrun <= 1'b0;
            end else if (tx_wr) begin
                overrun <= 1'b1;
            end
            if (state == S_INHIBIT && inh_cnt != '0) begin
                inh_cnt <= inh_cnt - INH_W'(1);
            end
            // send_oe holds the start bit until the first device fall, then bit 9 releases for stop.
            if (state == S_START) begin
                bit_cnt <= '0;
                send_oe <= 1'b1;
            end else if (state == S_SEND && fall) begin
                send_oe <= (bit_cnt == 4'd9) ? 1'b0 : ~shift_q[bit_cnt];
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (ack_take) begin
                if (dat_s) error  <= 1'b1;
                else       ack_ok <= 1'b1;
            end
            if (tmo_abort) error <= 1'b1;
        end
    end

    assign data = (address == 64'(STAT_ADDR) && read)
                  ? {60'b0, overrun, error, ack_ok, busy} : {64{1'bz}};

endmodule
